// File: rtl/axi4_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter: round-robin grant, one transaction in flight,
// combinational R pass-through, SLVERR substitution when the slave stalls too long.
module axi4_rd_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    // master 0 (instruction port)
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic [ID_W-1:0]   m0_rid,
    input  logic              m0_rready,
    // master 1 (data port)
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic [ID_W-1:0]   m1_rid,
    input  logic              m1_rready,
    // shared slave
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [ID_W-1:0]   s_rid,
    output logic              s_rready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              any_req;
    logic              winner;
    logic              g_rready;
    logic [ID_W-1:0]   grant_id;

    assign any_req  = m0_arvalid | m1_arvalid;
    // Under contention the master that did not win last time gets the grant.
    assign winner   = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
    assign g_rready = grant_q ? m1_rready : m0_rready;
    assign grant_id = ID_W'(grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;

        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rlast   = 1'b0;
        m0_rid     = '0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rlast   = 1'b0;
        m1_rid     = '0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arid     = '0;
        s_rready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Stray beats from an abandoned transaction are drained here.
                s_rready = 1'b1;
                if (any_req) begin
                    if (winner) begin
                        m1_arready = 1'b1;
                        addr_d     = m1_araddr;
                    end else begin
                        m0_arready = 1'b1;
                        addr_d     = m0_araddr;
                    end
                    grant_d = winner;
                    last_d  = winner;
                    state_d = StAddr;
                end
            end

            StAddr: begin
                s_arvalid = 1'b1;
                s_araddr  = addr_q;
                s_arid    = grant_id;
                if (s_arready) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end

            StData: begin
                s_rready = g_rready;
                if (grant_q) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rid    = s_rid;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rid    = s_rid;
                end
                // A handshake in the final allowed cycle takes priority over the timeout.
                if (s_rvalid && g_rready) begin
                    cnt_d = '0;
                    if (s_rlast) begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StErr: begin
                s_rready = 1'b1;
                if (grant_q) begin
                    m1_rvalid = 1'b1;
                    m1_rresp  = 2'b10;
                    m1_rlast  = 1'b1;
                    m1_rid    = grant_id;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rresp  = 2'b10;
                    m0_rlast  = 1'b1;
                    m0_rid    = grant_id;
                end
                if (g_rready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter (TIMEOUT=8): single read, contention order, backpressured
// burst, timeout SLVERR, timeout boundary and asynchronous reset mid-transaction.
module tb_axi4_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_arvalid, m1_arvalid;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arready, m1_arready;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast;
    logic [3:0]  m0_rid, m1_rid;
    logic        m0_rready, m1_rready;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        s_rready;

    int vectors     = 0;
    int miscompares = 0;

    axi4_rd_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .ID_W   (4),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_arvalid(m0_arvalid),
        .m0_araddr (m0_araddr),
        .m0_arready(m0_arready),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_rresp  (m0_rresp),
        .m0_rlast  (m0_rlast),
        .m0_rid    (m0_rid),
        .m0_rready (m0_rready),
        .m1_arvalid(m1_arvalid),
        .m1_araddr (m1_araddr),
        .m1_arready(m1_arready),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_rresp  (m1_rresp),
        .m1_rlast  (m1_rlast),
        .m1_rid    (m1_rid),
        .m1_rready (m1_rready),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arid    (s_arid),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master handshake, two ADDR cycles with the slave stalling, then slave accepts -> DATA.
    task automatic addr_phase(input logic who, input logic [31:0] a);
        if (who) begin
            m1_arvalid = 1'b1;
            m1_araddr  = a;
        end else begin
            m0_arvalid = 1'b1;
            m0_araddr  = a;
        end
        #1;
        chk("ap_arready", who ? m1_arready : m0_arready, 1);
        tick();
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        #1;
        chk("ap_arvalid", s_arvalid, 1);
        chk("ap_araddr", s_araddr, a);
        chk("ap_arid", s_arid, {31'd0, who});
        tick();
        chk("ap_arvalid_hold", s_arvalid, 1);
        chk("ap_no_arready", m0_arready | m1_arready, 0);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
    endtask

    logic [31:0] bd [4];
    int          k;
    logic        eg;

    initial begin
        rst_n = 1'b0;
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = 0; m1_araddr = 0;
        m0_rready = 0; m1_rready = 0; s_arready = 0;
        s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
        bd[0] = 32'h1111_0000; bd[1] = 32'h2222_0001; bd[2] = 32'h3333_0002; bd[3] = 32'h4444_0003;

        // Reset values
        #2;
        chk("rst_arvalid", s_arvalid, 0);
        chk("rst_araddr", s_araddr, 0);
        chk("rst_arid", s_arid, 0);
        chk("rst_rready", s_rready, 1);
        chk("rst_arready", {m1_arready, m0_arready}, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("rst_rlast", {m1_rlast, m0_rlast}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request from m0, beat after 3 DATA cycles
        addr_phase(1'b0, 32'h0000_1000);
        m0_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("single_wait_rvalid", m0_rvalid, 0);
            tick();
        end
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; s_rlast = 1; s_rid = 0;
        #1;
        chk("single_rvalid", m0_rvalid, 1);
        chk("single_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("single_rresp", m0_rresp, 0);
        chk("single_rlast", m0_rlast, 1);
        chk("single_m1_rvalid", m1_rvalid, 0);
        chk("single_s_rready", s_rready, 1);
        tick();
        s_rvalid = 0; s_rlast = 0;
        #1;
        chk("single_idle_rvalid", m0_rvalid, 0);

        // Contention from reset: m0, m1, m0, m1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h2000; m1_araddr = 32'h3000;
        m0_rready = 1; m1_rready = 1;
        for (int t = 0; t < 4; t++) begin
            eg = (t % 2 == 1);
            #1;
            chk("cont_arready0", m0_arready, eg ? 0 : 1);
            chk("cont_arready1", m1_arready, eg ? 1 : 0);
            tick();
            chk("cont_arid", s_arid, eg ? 1 : 0);
            chk("cont_araddr", s_araddr, eg ? 32'h3000 : 32'h2000);
            s_arready = 1;
            tick();
            s_arready = 0;
            s_rvalid = 1; s_rlast = 1; s_rdata = 32'(t); s_rid = {3'd0, eg};
            #1;
            chk("cont_rvalid_granted", eg ? m1_rvalid : m0_rvalid, 1);
            chk("cont_rvalid_other", eg ? m0_rvalid : m1_rvalid, 0);
            tick();
            s_rvalid = 0; s_rlast = 0;
        end
        m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;

        // m1 4-beat burst with toggling rready; m0 waits meanwhile
        addr_phase(1'b1, 32'h0000_4000);
        m0_arvalid = 1; m0_araddr = 32'h0000_5000;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            m1_rready = (c % 2 == 1);
            s_rvalid = 1; s_rdata = bd[k]; s_rlast = (k == 3); s_rid = 4'd1; s_rresp = 0;
            #1;
            chk("burst_s_rready", s_rready, (c % 2 == 1) ? 1 : 0);
            chk("burst_rvalid", m1_rvalid, 1);
            chk("burst_rdata", m1_rdata, bd[k]);
            chk("burst_rlast", m1_rlast, (k == 3) ? 1 : 0);
            chk("burst_m0_wait", m0_arready, 0);
            tick();
            if (c % 2 == 1) k++;
        end
        s_rvalid = 0; s_rlast = 0; m1_rready = 0;
        #1;
        chk("burst_beats", 32'(k), 4);
        chk("burst_idle_rvalid", m1_rvalid, 0);
        chk("burst_m0_granted", m0_arready, 1);

        // Timeout: m0 read, slave never answers
        addr_phase(1'b0, 32'h0000_5000);
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_rvalid", m0_rvalid, 0);
            tick();
        end
        chk("to_rvalid", m0_rvalid, 1);
        chk("to_rresp", m0_rresp, 2'b10);
        chk("to_rlast", m0_rlast, 1);
        chk("to_rdata", m0_rdata, 0);
        chk("to_rid", m0_rid, 0);
        chk("to_m1_rvalid", m1_rvalid, 0);
        s_rvalid = 1; s_rdata = 32'h5555_5555; s_rlast = 1;
        #1;
        chk("to_late_rdata", m0_rdata, 0);
        chk("to_s_rready", s_rready, 1);
        m0_rready = 1;
        tick();
        chk("to_idle_rvalid", m0_rvalid, 0);
        chk("to_drain_rready", s_rready, 1);
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;

        // Timeout boundary: beat arrives with counter at TIMEOUT-1
        addr_phase(1'b1, 32'h0000_6000);
        m1_rready = 1;
        for (int i = 0; i < 7; i++) begin
            chk("bnd_wait_rvalid", m1_rvalid, 0);
            tick();
        end
        s_rvalid = 1; s_rlast = 1; s_rdata = 32'hCAFE_F00D; s_rresp = 0; s_rid = 4'd1;
        #1;
        chk("bnd_rvalid", m1_rvalid, 1);
        chk("bnd_rresp", m1_rresp, 0);
        chk("bnd_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("bnd_rid", m1_rid, 1);
        tick();
        s_rvalid = 0; s_rlast = 0; m1_rready = 0;
        #1;
        chk("bnd_no_err", m1_rvalid, 0);

        // Asynchronous reset mid-burst
        addr_phase(1'b0, 32'h0000_7000);
        m0_rready = 1; s_rvalid = 1; s_rlast = 0; s_rdata = 32'h1234_5678; s_rid = 0;
        tick();
        chk("mid_rvalid", m0_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_arvalid", s_arvalid, 0);
        chk("arst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("arst_rdata", m0_rdata, 0);
        chk("arst_s_rready", s_rready, 1);
        rst_n = 1'b1;
        m0_arvalid = 1; m1_arvalid = 1;
        #1;
        chk("arst_m0_first", m0_arready, 1);
        chk("arst_m1_waits", m1_arready, 0);
        tick();
        m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_rd_arbiter.md
# axi4_rd_arbiter

Two-master to one-slave AXI4 read-channel arbiter. It sits between the eclass core's instruction read port (master 0) and data read port (master 1), and the single shared memory read port of the basic SoC. It grants one read transaction at a time with round-robin priority, forwards R beats back to the granted master, and replaces a stalled transaction with a SLVERR response after a programmable timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI ID width (≥1)
- TIMEOUT, 1024, cycles allowed in DATA without an R handshake before the error response; ≥2, counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_arvalid, m1_arvalid  in  1  master read-address valid
- m0_araddr, m1_araddr  in  ADDR_W  master read address
- m0_arready, m1_arready  out  1  address accepted by arbiter
- m0_rvalid, m1_rvalid  out  1  read data valid to master
- m0_rdata, m1_rdata  out  DATA_W  read data
- m0_rresp, m1_rresp  out  2  read response
- m0_rlast, m1_rlast  out  1  last beat
- m0_rid, m1_rid  out  ID_W  response ID
- m0_rready, m1_rready  in  1  master ready for R beat
- s_arvalid  out  1  slave address valid
- s_araddr  out  ADDR_W  slave address
- s_arid  out  ID_W  slave ID = {zeros, granted index}
- s_arready  in  1  slave accepts address
- s_rvalid, s_rdata, s_rresp, s_rlast, s_rid  in  1/DATA_W/2/1/ID_W  slave R channel
- s_rready  out  1  ready toward slave

## Operation
- FSM states: IDLE, ADDR, DATA, ERR. Reset state is IDLE. grant_q resets to 0. last_q resets to 1, so master 0 wins the first contention.
- IDLE:
  - Winner is the only requester, or, if both request, the master ≠ last_q.
  - Winner's mX_arready=1 combinationally. On that handshake, latch araddr into addr_q and the index into grant_q and last_q, then go to ADDR.
  - s_rready=1; stray slave beats are dropped.
- ADDR: s_arvalid=1, s_araddr=addr_q, s_arid=grant_q zero-extended. On s_arready go to DATA and clear the timeout counter. Both mX_arready stay 0.
- DATA:
  - Granted master's rvalid/rdata/rresp/rlast/rid mirror the s_r* signals combinationally. s_rready = granted master's rready.
  - The non-granted master sees rvalid=0.
  - Each R handshake clears the counter. A handshake with s_rlast=1 returns the FSM to IDLE.
  - Cycles without a handshake increment the counter. When it reaches TIMEOUT-1 with no handshake that cycle, go to ERR.
- ERR:
  - Granted master sees rvalid=1, rresp=2'b10, rlast=1, rdata=0, rid=s_arid value.
  - s_rready=1, so late slave beats are discarded.
  - On the granted mX_rready go to IDLE.
- Outside DATA and ERR, all mX_rvalid=0. Outside ADDR, s_arvalid=0.
- A master's arvalid asserted while the other holds the grant waits. No request is lost, and arready is not raised until the FSM returns to IDLE.

## Timing
- Reset values: s_arvalid=0, s_araddr=0, s_arid=0, s_rready=1 (IDLE), all mX_arready=0 with no requests, all mX_rvalid/rlast=0, rresp/rdata/rid=0.
- Address latency: master handshake in cycle N gives s_arvalid=1 in N+1. s_arvalid holds until s_arready.
- R path: zero-cycle combinational pass-through, no buffering.
- Re-arbitration: the first IDLE cycle after rlast (or after the ERR handshake) can accept a new request. Minimum spacing is 1 IDLE cycle between transactions.
- Simultaneous s_rvalid&&rready and counter at TIMEOUT-1: the handshake wins and there is no ERR.
- Asynchronous reset mid-transaction: immediate return to IDLE, outputs to reset values. The open slave transaction is abandoned; its beats are drained in IDLE.

## Test plan
- Single request: m0 reads 0x1000, slave returns 0xDEADBEEF with rlast after 3 cycles -> s_araddr=0x1000 and s_arid=0 in the cycle after the m0 handshake; m0 sees one beat 0xDEADBEEF, rresp=00; m1_rvalid stays 0.
- Contention from reset: m0 and m1 request together, twice -> order is m0, m1, m0, m1; s_arid alternates 0,1.
- Burst with backpressure: m1 4-beat read with m1_rready toggling -> s_rready follows m1_rready, all 4 beats delivered in order, return to IDLE only after rlast.
- Timeout: TIMEOUT=8, slave never sends R -> after 8 DATA cycles m0 sees rvalid=1, rresp=10, rlast=1, rdata=0; FSM returns to IDLE; a late slave beat is dropped.
- Timeout boundary: slave beat arrives exactly at counter=TIMEOUT-1 -> normal beat delivered, no SLVERR.
- Reset mid-DATA: assert rst_n=0 mid-burst -> s_arvalid=0 and all rvalid=0 immediately; next contention grants m0 first.
